// File: rtl/dfd_cla_debug_signals_pattern_gen_if.sv
// dfd_cla_debug_signals_pattern_gen_if: run control and pattern outputs of the CLA debug pattern generator; DFD_CLA_PATGEN_MASK_EN adds mask
interface dfd_cla_debug_signals_pattern_gen_if #(
  parameter int DEBUG_SIGNALS_WIDTH = 64,
  parameter int HOLD_CNT_WIDTH = 16
);
  logic start;
  logic stop;
  logic [1:0] mode;
  logic [HOLD_CNT_WIDTH-1:0] hold_cycles;
  logic [HOLD_CNT_WIDTH-1:0] num_steps;
  logic [DEBUG_SIGNALS_WIDTH-1:0] seed;
  logic [DEBUG_SIGNALS_WIDTH-1:0] debug_signals;
  logic change_strobe;
  logic busy;
  logic done;
`ifdef DFD_CLA_PATGEN_MASK_EN
  logic [DEBUG_SIGNALS_WIDTH-1:0] mask;
`endif
  modport master (
`ifdef DFD_CLA_PATGEN_MASK_EN
    output mask,
`endif
    output start, stop, mode, hold_cycles, num_steps, seed,
    input debug_signals, change_strobe, busy, done
  );
  modport slave (
`ifdef DFD_CLA_PATGEN_MASK_EN
    input mask,
`endif
    input start, stop, mode, hold_cycles, num_steps, seed,
    output debug_signals, change_strobe, busy, done
  );
endinterface

// File: rtl/dfd_cla_debug_signals_pattern_gen.sv
// dfd_cla_debug_signals_pattern_gen: static/walking-one/counter/LFSR stimulus for the CLA debug bus
// DFD_CLA_PATGEN_MASK_EN: gates the output with a live mask while the internal pattern evolves unmasked
module dfd_cla_debug_signals_pattern_gen #(
  parameter int DEBUG_SIGNALS_WIDTH = 64,
  parameter int HOLD_CNT_WIDTH = 16,
  parameter logic [63:0] LFSR_TAPS = 64'h1B
) (
  input logic clock,
  input logic reset,
  dfd_cla_debug_signals_pattern_gen_if.slave bus
);
  localparam int W = DEBUG_SIGNALS_WIDTH;
  localparam int H = HOLD_CNT_WIDTH;
  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [H-1:0] hold_q, hold_d, steps_q, steps_d;
  logic [H-1:0] hold_cnt_q, hold_cnt_d, step_cnt_q, step_cnt_d;
  logic [W-1:0] pat_q, pat_d, dbg_q, dbg_d, pat_next, seed_eff, mask_w;
  logic strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;
  logic start_ok, stop_ok, step_en, last_step;
`ifdef DFD_CLA_PATGEN_MASK_EN
  assign mask_w = bus.mask;
`else
  assign mask_w = '1;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= '0;
      hold_q <= '0;
      steps_q <= '0;
      hold_cnt_q <= '0;
      step_cnt_q <= '0;
      pat_q <= '0;
      dbg_q <= '0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      hold_q <= hold_d;
      steps_q <= steps_d;
      hold_cnt_q <= hold_cnt_d;
      step_cnt_q <= step_cnt_d;
      pat_q <= pat_d;
      dbg_q <= dbg_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  // stop outranks both start and a pending step
  always_comb begin
    start_ok = state_q == IDLE && bus.start && !bus.stop;
    stop_ok = state_q == RUN && bus.stop;
    step_en = state_q == RUN && !bus.stop && hold_cnt_q == hold_q;
    last_step = step_en && steps_q != '0 && (step_cnt_q + H'(1)) == steps_q;
    state_d = start_ok ? RUN : (stop_ok || last_step) ? IDLE : state_q;
  end
  always_comb begin
    seed_eff = (bus.mode[0] && bus.seed == '0) ? W'(1) : bus.seed;
    pat_next = mode_q == 2'd0 ? pat_q :
               mode_q == 2'd1 ? {pat_q[W-2:0], pat_q[W-1]} :
               mode_q == 2'd2 ? pat_q + W'(1) :
               {pat_q[W-2:0], 1'b0} ^ (pat_q[W-1] ? TAPS : '0);
    mode_d = start_ok ? bus.mode : mode_q;
    hold_d = start_ok ? bus.hold_cycles : hold_q;
    steps_d = start_ok ? bus.num_steps : steps_q;
    hold_cnt_d = start_ok ? '0 :
                 (state_q == RUN && !bus.stop) ? (step_en ? '0 : hold_cnt_q + H'(1)) : hold_cnt_q;
    step_cnt_d = start_ok ? '0 : (step_en && step_cnt_q != '1) ? step_cnt_q + H'(1) : step_cnt_q;
    pat_d = start_ok ? seed_eff : step_en ? pat_next : pat_q;
    dbg_d = pat_d & mask_w;
    strobe_d = dbg_d != dbg_q;
    busy_d = state_d == RUN;
    done_d = last_step;
  end
  always_comb begin
    bus.debug_signals = dbg_q;
    bus.change_strobe = strobe_q;
    bus.busy = busy_q;
    bus.done = done_q;
  end
endmodule

// File: tb/tb_dfd_cla_debug_signals_pattern_gen.sv
// tb_dfd_cla_debug_signals_pattern_gen: directed checks of load, stepping, bounds, stop and reset behaviour
module tb_dfd_cla_debug_signals_pattern_gen;
  logic clock, reset;
  int checks = 0;
  int failures = 0;
  dfd_cla_debug_signals_pattern_gen_if #(.DEBUG_SIGNALS_WIDTH(64), .HOLD_CNT_WIDTH(16)) bus ();
  dfd_cla_debug_signals_pattern_gen #(.DEBUG_SIGNALS_WIDTH(64), .HOLD_CNT_WIDTH(16), .LFSR_TAPS(64'h1B)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [63:0] dbg, input logic strobe, input logic busy, input logic done);
    chk({tag, ".dbg"}, bus.debug_signals, dbg);
    chk({tag, ".strobe"}, 64'(bus.change_strobe), 64'(strobe));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(busy));
    chk({tag, ".done"}, 64'(bus.done), 64'(done));
  endtask
  task automatic cfg(input logic [1:0] m, input logic [63:0] s, input logic [15:0] h, input logic [15:0] n);
    bus.mode = m;
    bus.seed = s;
    bus.hold_cycles = h;
    bus.num_steps = n;
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    cfg(2'd0, 64'h0, 16'd0, 16'd0);
`ifdef DFD_CLA_PATGEN_MASK_EN
    bus.mask = '1;
`endif
    tick();
    tick();
    chk_out("reset", 64'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("idle", 64'h0, 1'b0, 1'b0, 1'b0);
    cfg(2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 16'd0, 16'd3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cfg(2'd0, 64'h0, 16'd7, 16'd0);
    chk_out("cnt.load", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("cnt.s1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("cnt.wrap", 64'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("cnt.done", 64'h1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("cnt.after", 64'h1, 1'b0, 1'b0, 1'b0);
    cfg(2'd1, 64'h0, 16'd2, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("walk.load", 64'h1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("walk.hold1", 64'h1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("walk.hold2", 64'h1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("walk.s1", 64'h2, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk_out("walk.s2", 64'h4, 1'b1, 1'b1, 1'b0);
    cfg(2'd2, 64'h55, 16'd0, 16'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("walk.start_busy", 64'h4, 1'b0, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("walk.stop", 64'h4, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("walk.held", 64'h4, 1'b0, 1'b0, 1'b0);
    cfg(2'd3, 64'h8000_0000_0000_0000, 16'd0, 16'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("lfsr.load", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("lfsr.done", 64'h1B, 1'b1, 1'b0, 1'b1);
    cfg(2'd0, 64'hA5, 16'd1, 16'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("stat.load", 64'hA5, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("stat.c1", 64'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("stat.c2", 64'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("stat.c3", 64'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("stat.done", 64'hA5, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("stat.after", 64'hA5, 1'b0, 1'b0, 1'b0);
    cfg(2'd2, 64'h77, 16'd0, 16'd0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk_out("startstop", 64'hA5, 1'b0, 1'b0, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("idle_stop", 64'hA5, 1'b0, 1'b0, 1'b0);
    cfg(2'd0, 64'hA5, 16'd0, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("reload_same", 64'hA5, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk_out("post_reset", 64'h0, 1'b0, 1'b0, 1'b0);
`ifdef DFD_CLA_PATGEN_MASK_EN
    bus.mask = 64'hFFFF_FFFF_FFFF_FFFE;
    cfg(2'd2, 64'h0, 16'd0, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_out("mask.load", 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("mask.s1", 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("mask.s2", 64'h2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("mask.s3", 64'h2, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("mask.s4", 64'h4, 1'b1, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_out("mask.stop", 64'h4, 1'b0, 1'b0, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dfd_cla_debug_signals_pattern_gen.md
Name: dfd_cla_debug_signals_pattern_gen

Overview:
Programmable stimulus source that drives the CLA debug_signals bus with deterministic patterns, so the CLA change/match logic can be self-tested on silicon. It sits upstream of the CLA debug-signal consumers, muxed in place of the functional debug bus. Patterns are static, walking-one, incrementing counter or LFSR. Each pattern step is held for a programmable number of cycles, and a run is optionally bounded by a step count.

Parameters:
DEBUG_SIGNALS_WIDTH, 64, width of the generated debug bus (>=2)
HOLD_CNT_WIDTH, 16, width of the hold-interval and step counters
LFSR_TAPS, 64'h1B, Galois feedback XOR mask, low DEBUG_SIGNALS_WIDTH bits used (default gives x^64+x^4+x^3+x+1)

Ports:
clock  input  1  block clock
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; samples config and begins a run (ignored while busy)
stop  input  1  pulse; aborts a run
mode  input  2  0 static, 1 walking-one, 2 counter, 3 LFSR
hold_cycles  input  HOLD_CNT_WIDTH  extra cycles each step is held (0 = new value every cycle)
num_steps  input  HOLD_CNT_WIDTH  steps per run after load (0 = unbounded)
seed  input  DEBUG_SIGNALS_WIDTH  initial pattern value
debug_signals  output  DEBUG_SIGNALS_WIDTH  generated pattern, registered
change_strobe  output  1  high in each cycle in which debug_signals differs from its previous-cycle value
busy  output  1  run in progress
done  output  1  one-cycle pulse when a bounded run completes

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: all outputs 0. State IDLE. Counters 0.
- FSM states: IDLE, RUN.
- IDLE, start=1:
  - Latch mode, hold_cycles and num_steps.
  - Next cycle: debug_signals=seed, busy=1, hold_cnt=0, step_cnt=0, go to RUN.
- Seed substitution: in modes 1 and 3, seed==0 loads 1 instead.
- RUN, per cycle:
  - If hold_cnt != hold_latched: hold_cnt++.
  - Otherwise: hold_cnt=0, debug_signals=next(debug_signals), step_cnt++.
- Step functions:
  - mode0: next = current.
  - mode1: rotate left by 1.
  - mode2: current+1, wraps modulo 2^W (all-ones -> 0).
  - mode3: (current<<1) ^ (current[W-1] ? LFSR_TAPS : 0).
- Bounded completion:
  - Applies when num_steps_latched != 0.
  - On the cycle the step making step_cnt==num_steps_latched is applied: done=1 for one cycle, busy=0, return to IDLE.
  - debug_signals retains its final value.
- Unbounded runs (num_steps 0): step_cnt saturates and never completes; the run ends only by stop.
- Step timing: step k appears (hold_cycles+1)*k cycles after the load cycle.
- stop in RUN:
  - Next cycle: IDLE, busy=0, no done.
  - debug_signals holds its value until the next start or reset.
- Simultaneous events:
  - stop and start in the same cycle: stop wins; start is ignored.
  - start while busy: ignored.
  - stop in IDLE: no effect.
- change_strobe is registered with debug_signals: 1 iff the new value != old value, including at load.
  - mode0 never strobes after load.
  - Reloading an identical seed gives no strobe.
- Reset mid-run: outputs and state cleared asynchronously; no done.
- Config inputs are ignored after start sampling.

Optional Feature:
DFD_CLA_PATGEN_MASK_EN:
- Defined: adds input port mask [DEBUG_SIGNALS_WIDTH-1:0].
  - debug_signals = internal_pattern & mask, with mask applied live each cycle.
  - The internal pattern evolves unmasked.
  - change_strobe compares masked values, so a step touching only masked-off bits produces no strobe.
- Undefined: no mask port; output equals the internal pattern.

Test Plan:
- Reset, then start with mode=2, seed=0xFFFF_FFFF_FFFF_FFFE, hold=0, steps=3 -> outputs …FE, …FF, 0x0, 0x1 on consecutive cycles; strobe 1 on all four; done on the 0x1 cycle; busy low after.
- mode=1, seed=0, hold=2, steps=0 -> load 0x1; 0x2 three cycles later; 0x4 six cycles later; stop -> busy 0 next cycle, value 0x4 held, no done.
- mode=3, seed=0x8000_0000_0000_0000, hold=0, steps=1 -> load, then 0x1B; done pulse.
- mode=0, seed=0xA5, steps=2, hold=1 -> strobe only at load; value 0xA5 throughout; done 4 cycles after load.
- start+stop same cycle in IDLE -> stays IDLE; start during a run -> ignored; reset asserted mid-run -> outputs 0 immediately.
- With DFD_CLA_PATGEN_MASK_EN, mask=0xFFFF_FFFF_FFFF_FFFE, mode=2, seed=0 -> strobe on every second step only.
